// File: rtl/rv32i_dmem_responder.sv
// Data-memory responder for the RV32I Mem stage.
// Each load or store is held off for WAIT_CYCLES cycles through stall_o, then
// executes against an internal word array. Load data, the load-valid pulse
// and the error pulse are registered so they line up with Write-back.
// Handshake: a request is live while req_we_i | req_re_i is high. The requester
// keeps addr/wdata/funct3 stable while stall_o is high. The access executes on
// the rising edge that ends the first cycle in which stall_o is low with the
// request still present. Dropping the request while waiting cancels it.
module rv32i_dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_we_i,
   input  logic        req_re_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [2:0]  funct3_i,
   output logic        stall_o,
   output logic [31:0] rdata_o,
   output logic        rvalid_o,
   output logic        err_o,
   output logic        dbg_wait_o
);

   localparam int unsigned AW = $clog2(DEPTH_WORDS);
   localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic          req;
   logic          is_store;
   logic          exec;
   logic [1:0]    size;
   logic          illegal_f3;
   logic          misaligned;
   logic          acc_err;
   logic [AW-1:0] idx;
   logic [31:0]   word;
   logic [31:0]   shifted;
   logic [31:0]   load_ext;
   logic [31:0]   rdata_q;
   logic          rvalid_q;
   logic          err_q;
   logic [31:0]   mem_q [DEPTH_WORDS];
   logic          unused_addr_bits;

   assign req      = req_we_i | req_re_i;
   assign is_store = req_we_i;
   assign size     = funct3_i[1:0];
   assign idx      = addr_i[AW+1:2];
   assign unused_addr_bits = ^addr_i[31:AW+2];

   // FSM state and wait counter register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next state, stall and execute strobe; reset blocks any pending access
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall_o = 1'b0;
      exec    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (WAIT_CYCLES == 0) begin
                  exec = 1'b1;
               end else begin
                  stall_o = 1'b1;
                  cnt_d   = WAIT_INIT;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               state_d = S_IDLE;
            end else if (cnt_q != 4'd0) begin
               stall_o = 1'b1;
               cnt_d   = cnt_q - 4'd1;
            end else begin
               exec    = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (reset_i) begin
         stall_o = 1'b0;
         exec    = 1'b0;
      end
   end

   // Decode funct3 legality and alignment for the current request
   always_comb begin
      if (is_store) begin
         illegal_f3 = funct3_i[2] | (size == 2'b11);
      end else begin
         illegal_f3 = (size == 2'b11) | (funct3_i[2] & (size == 2'b10));
      end
      misaligned = ((size == 2'b01) & addr_i[0]) |
                   ((size == 2'b10) & (addr_i[1:0] != 2'b00));
      acc_err    = illegal_f3 | misaligned;
   end

   // Load lane select and sign/zero extension
   always_comb begin
      word    = mem_q[idx];
      shifted = word >> {addr_i[1:0], 3'b000};
      case (size)
         2'b00:   load_ext = funct3_i[2] ? {24'd0, shifted[7:0]}
                                         : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   load_ext = funct3_i[2] ? {16'd0, shifted[15:0]}
                                         : {{16{shifted[15]}}, shifted[15:0]};
         default: load_ext = word;
      endcase
   end

   // Byte-lane store into the word array (contents are never reset)
   always_ff @(posedge clk_i) begin
      if (exec && is_store && !acc_err) begin
         case (size)
            2'b00:   mem_q[idx][{addr_i[1:0], 3'b000} +: 8]  <= wdata_i[7:0];
            2'b01:   mem_q[idx][{addr_i[1], 4'b0000} +: 16]  <= wdata_i[15:0];
            default: mem_q[idx] <= wdata_i;
         endcase
      end
   end

   // Write-back aligned response: data, valid pulse and error pulse
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         rdata_q  <= 32'd0;
         rvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         rvalid_q <= exec & ~is_store;
         err_q    <= exec & acc_err;
         if (exec && !is_store) begin
            rdata_q <= acc_err ? 32'd0 : load_ext;
         end
      end
   end

   assign rdata_o    = rdata_q;
   assign rvalid_o   = rvalid_q;
   assign err_o      = err_q;
   assign dbg_wait_o = (state_q == S_WAIT);

endmodule
